sdes_iterative_core: RTL
========================

Name: sdes_iterative_core

Overview:
Sequential S-DES engine that replaces the combinational Encrypt/Decrypt pair downstream of key_gen. It consumes the 8-bit message and the two 8-bit subkeys, and runs IP, fk, SW, fk and IP^-1 over three clocked steps under a start/busy/done handshake. Its registered result feeds the display/result register path of the board wrapper.

Parameters:
None. Widths are fixed: 8-bit block and 8-bit subkeys.

Ports:
CLOCK_50  input  1  system clock; all state changes on its rising edge
RESET  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
encrypt  input  1  1 = encrypt (K1 then K2); 0 = decrypt (K2 then K1); latched at start
msg_in  input  8  plaintext or ciphertext; latched at start
subkey1  input  8  K1 from key_gen; latched at start
subkey2  input  8  K2 from key_gen; latched at start
data_out  output  8  result; registered; holds its value until the next completion
busy  output  1  high whenever the FSM is not in IDLE
done  output  1  one-cycle completion pulse

Behaviour:
- Bit numbering: bit 1 is the MSB (msg_in[7]). Permutations list source bit positions.
- IP = 2 6 3 1 4 8 5 7.
- IP^-1 = 4 1 3 5 7 2 8 6.
- E/P (on the right nibble, positions 1-4) = 4 1 2 3 2 3 4 1.
- P4 = 2 4 3 1.
- fk(L,R,K) = (L XOR F(R,K), R). F = P4(S0 || S1) applied to E/P(R) XOR K.
- S-box row = outer bits (1,4); column = inner bits (2,3).
- S0 rows: 1 0 3 2 / 3 2 1 0 / 0 2 1 3 / 3 1 3 2.
- S1 rows: 0 1 2 3 / 2 0 1 3 / 3 0 1 0 / 2 1 0 3.
- Key order: encrypt uses ka = K1, kb = K2. Decrypt uses ka = K2, kb = K1.
- FSM states: IDLE, R1, R2, DONE.
  - IDLE, start = 1 at edge N: latch mode and keys; state_reg <= IP(msg_in); go to R1.
  - IDLE, start = 0: stay in IDLE.
  - R1 (edge N+1): state_reg <= SW(fk(state_reg, ka)); go to R2.
  - R2 (edge N+2): data_out <= IP^-1(fk(state_reg, kb)); done <= 1; go to DONE.
  - DONE (edge N+3): done <= 0; go to IDLE. A new start is accepted from edge N+4.
- Latency: done is high for exactly one cycle after edge N+2, and data_out is valid in that same cycle. Throughput is one block per 4 cycles.
- busy = (state != IDLE). It is combinational from the state register.
- start while busy (R1, R2 or DONE) is ignored and not queued.
- Input changes after start is accepted have no effect on the running operation.
- data_out is updated only in R2. A start alone does not clear it.
- Reset (including mid-operation) sets: FSM = IDLE, data_out = 8'h00, done = 0, busy = 0, internal latches = 0.
- If RESET and start are both high on the same edge, reset wins and start is dropped.
- No combinational path from any input to data_out or done.

Test Plan:
1. Reset, then encrypt = 1, msg_in = 8'b10010111, K1 = 8'b10100100, K2 = 8'b01000011, start for 1 cycle -> done pulses 3 edges later with data_out = 8'b00111000; busy is high for 3 cycles.
2. Same keys, encrypt = 0, msg_in = 8'b00111000 -> data_out = 8'b10010111 at the done pulse; the previous data_out is held until that pulse.
3. Hold start high continuously -> ops are accepted every 4 cycles only; done pulses once per op; no start is accepted in R1, R2 or DONE.
4. Change msg_in, subkey1, subkey2 and encrypt during R1/R2 -> result is unchanged from test 1 (8'b00111000).
5. Assert RESET during R2 -> no done pulse; data_out = 8'h00; busy = 0 next cycle; a fresh start then completes normally.
6. Randomized: 200 random key/message pairs -> encrypt then decrypt through the core returns the original message, and results match a reference S-DES model.

Source files
------------

// File: rtl/sdes_iterative_core.sv
// Iterative S-DES engine: IP on accept, one fk+SW step, then fk+IP^-1 into the result register.
// Three clocked steps per block with a start/busy/done handshake and a one-cycle return to IDLE.
module sdes_iterative_core (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       start,
  input  logic       encrypt,
  input  logic [7:0] msg_in,
  input  logic [7:0] subkey1,
  input  logic [7:0] subkey2,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       done
);

  // Handshake: start is sampled only in IDLE. busy is high from the accepting edge
  // until the FSM returns to IDLE. done is a one-cycle pulse coincident with valid data_out.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_R1   = 2'd1;
  localparam logic [1:0] ST_R2   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0] r_state;
  logic [7:0] r_block;
  logic [7:0] r_ka;
  logic [7:0] r_kb;
  logic [7:0] r_data_out;
  logic       r_done;

  logic [7:0] w_ip;
  logic [7:0] w_round_key;
  logic [7:0] w_fk;
  logic [7:0] w_swapped;
  logic [7:0] w_final;

  function automatic logic [7:0] f_ip(input logic [7:0] x);
    f_ip = {x[6], x[2], x[5], x[7], x[4], x[0], x[3], x[1]};
  endfunction

  function automatic logic [7:0] f_ip_inv(input logic [7:0] x);
    f_ip_inv = {x[4], x[7], x[5], x[3], x[1], x[6], x[0], x[2]};
  endfunction

  function automatic logic [7:0] f_ep(input logic [3:0] r);
    f_ep = {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]};
  endfunction

  function automatic logic [3:0] f_p4(input logic [3:0] s);
    f_p4 = {s[2], s[0], s[1], s[3]};
  endfunction

  // Case selector is {row, col}: row from outer bits, column from inner bits.
  function automatic logic [1:0] f_s0(input logic [3:0] v);
    logic [1:0] res;
    case ({v[3], v[0], v[2], v[1]})
      4'd0:    res = 2'd1;
      4'd1:    res = 2'd0;
      4'd2:    res = 2'd3;
      4'd3:    res = 2'd2;
      4'd4:    res = 2'd3;
      4'd5:    res = 2'd2;
      4'd6:    res = 2'd1;
      4'd7:    res = 2'd0;
      4'd8:    res = 2'd0;
      4'd9:    res = 2'd2;
      4'd10:   res = 2'd1;
      4'd11:   res = 2'd3;
      4'd12:   res = 2'd3;
      4'd13:   res = 2'd1;
      4'd14:   res = 2'd3;
      default: res = 2'd2;
    endcase
    f_s0 = res;
  endfunction

  function automatic logic [1:0] f_s1(input logic [3:0] v);
    logic [1:0] res;
    case ({v[3], v[0], v[2], v[1]})
      4'd0:    res = 2'd0;
      4'd1:    res = 2'd1;
      4'd2:    res = 2'd2;
      4'd3:    res = 2'd3;
      4'd4:    res = 2'd2;
      4'd5:    res = 2'd0;
      4'd6:    res = 2'd1;
      4'd7:    res = 2'd3;
      4'd8:    res = 2'd3;
      4'd9:    res = 2'd0;
      4'd10:   res = 2'd1;
      4'd11:   res = 2'd0;
      4'd12:   res = 2'd2;
      4'd13:   res = 2'd1;
      4'd14:   res = 2'd0;
      default: res = 2'd3;
    endcase
    f_s1 = res;
  endfunction

  function automatic logic [3:0] f_round(input logic [3:0] r, input logic [7:0] k);
    logic [7:0] mixed;
    mixed   = f_ep(r) ^ k;
    f_round = f_p4({f_s0(mixed[7:4]), f_s1(mixed[3:0])});
  endfunction

  function automatic logic [7:0] f_fk(input logic [7:0] blk, input logic [7:0] k);
    f_fk = {blk[7:4] ^ f_round(blk[3:0], k), blk[3:0]};
  endfunction

  // Single shared fk datapath; the round key is chosen by which step is executing.
  assign w_ip        = f_ip(msg_in);
  assign w_round_key = (r_state == ST_R1) ? r_ka : r_kb;
  assign w_fk        = f_fk(r_block, w_round_key);
  assign w_swapped   = {w_fk[3:0], w_fk[7:4]};
  assign w_final     = f_ip_inv(w_fk);

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_state    <= ST_IDLE;
      r_block    <= 8'h00;
      r_ka       <= 8'h00;
      r_kb       <= 8'h00;
      r_data_out <= 8'h00;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_block <= w_ip;
            r_ka    <= encrypt ? subkey1 : subkey2;
            r_kb    <= encrypt ? subkey2 : subkey1;
            r_state <= ST_R1;
          end
        end
        ST_R1: begin
          r_block <= w_swapped;
          r_state <= ST_R2;
        end
        ST_R2: begin
          r_data_out <= w_final;
          r_done     <= 1'b1;
          r_state    <= ST_DONE;
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign data_out = r_data_out;
  assign done     = r_done;
  assign busy     = (r_state != ST_IDLE);

endmodule
